// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its clear controller.
package regfile_pkg;

    typedef logic [0:0] rf_state_t;

    localparam rf_state_t RF_IDLE  = 1'b0;
    localparam rf_state_t RF_CLEAR = 1'b1;

    localparam int MAX_RD = 4;
    localparam int MAX_WR = 2;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequential clear engine: walks clr_idx over every entry, one per cycle,
// after a clear_req pulse; clear_busy is the registered CLEAR state.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RF_IDLE: begin
                if (clear_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
            RF_CLEAR: begin
                // Requests arriving mid-clear are ignored; the walk never restarts.
                if (idx_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = RF_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign clr_en     = (state_q == RF_CLEAR);
    assign clear_busy = (state_q == RF_CLEAR);
    assign clr_idx    = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-first registered reads,
// optional hardwired-zero r0 and a sequential full-array clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     clear_req,
    output logic                     clear_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (NUM_RD < 1 || NUM_RD > MAX_RD || NUM_WR < 1 || NUM_WR > MAX_WR) begin : g_param_check
        $error("regfile_mp: unsupported read/write port count");
    end

    logic              clr_en;
    logic [ADDR_W-1:0] clr_idx;

    logic [ADDR_W-1:0] wa     [NUM_WR];
    logic [DATA_W-1:0] wd     [NUM_WR];
    logic [NUM_WR-1:0] wr_ok;

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [DATA_W-1:0] mem_d  [DEPTH];

    regfile_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clr_en     (clr_en),
        .clr_idx    (clr_idx)
    );

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign wa[j]    = wr_addr[j*ADDR_W +: ADDR_W];
        assign wd[j]    = wr_data[j*DATA_W +: DATA_W];
        assign wr_ok[j] = wr_en[j] && !clr_en;
    end

    // mem_d is the array as it stands after this edge; reads sample it, which
    // gives write-first bypass, clear-first during CLEAR and highest-port-wins.
    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_idx] = '0;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j]) begin
                mem_d[wa[j]] = wd[j];
            end
        end
        if (ZERO_R0 != 0) begin
            mem_d[0] = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_data_d;
        logic [DATA_W-1:0] rd_data_q;

        assign ra        = rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_data_d = mem_d[ra];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = rd_data_q;
    end

endmodule
